// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states and
// small op-classification helpers.
package mdu_pkg;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath: conditional add-and-shift-right
// for multiply, restoring trial-subtract-and-shift-left for divide.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   mul_next;
    logic [2*WIDTH-1:0]   div_next;

    // Multiply: acc = {partial_sum, remaining multiplier bits}; the carry out of
    // the add becomes the new top bit after the right shift.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        mul_next = {sum, acc[WIDTH-1:1]};
    end

    // Divide: acc = {remainder, dividend/quotient}; diff[WIDTH] is the borrow.
    always_comb begin
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        if (diff[WIDTH]) begin
            div_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        acc_next = is_div ? div_next : mul_next;
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers,
// start/busy/done handshake and MTHI/MTLO write port.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [WIDTH-1:0]  wdata,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     opnd;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 neg_res;
    logic                 neg_rem;
    logic                 dbz_q;

    logic                 sgn;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (op_is_div(op_q)),
        .acc      (acc),
        .operand  (opnd),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ITER;
            ITER:    if (cnt == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Operands are iterated as magnitudes; signs are restored in FIX.
    always_comb begin
        sgn   = op_is_signed(op);
        abs_a = (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
        abs_b = (sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;
    end

    always_comb begin
        prod   = neg_res ? (~acc + 1'b1) : acc;
        quo    = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem    = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (op_is_div(op_q)) begin
            if (dbz_q) begin
                fix_hi = a_q;
                fix_lo = '1;
            end else begin
                fix_hi = rem;
                fix_lo = quo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            op_q        <= MD_MULT;
            a_q         <= '0;
            opnd        <= '0;
            acc         <= '0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= a;
                        opnd    <= abs_b;
                        acc     <= {{WIDTH{1'b0}}, abs_a};
                        neg_res <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem <= sgn && op_is_div(op) && a[WIDTH-1];
                        dbz_q   <= op_is_div(op) && (b == '0);
                        cnt     <= CNT_W'(WIDTH - 1);
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                ITER: begin
                    acc <= acc_next;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                FIX: begin
                    hi          <= fix_hi;
                    lo          <= fix_lo;
                    done        <= 1'b1;
                    div_by_zero <= dbz_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multi-cycle MIPS multiply/divide unit holding the architectural HI/LO registers. It runs MULT, MULTU, DIV and DIVU iteratively over WIDTH cycles using a start/busy/done handshake. It also serves MTHI/MTLO writes and continuously drives hi/lo for MFHI/MFLO. It sits beside the single-cycle ALU in the execute stage; the pipeline stalls on busy.

Parameters:
WIDTH, 32, operand width and HI/LO register width; legal range is WIDTH >= 2.
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, never overridden.

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request an operation; sampled only while busy=0
op  in  2  operation select: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU
a  in  WIDTH  multiplicand / dividend
b  in  WIDTH  multiplier / divisor
mthi  in  1  write wdata to HI
mtlo  in  1  write wdata to LO
wdata  in  WIDTH  MTHI/MTLO data
busy  out  1  operation in progress
done  out  1  one-cycle pulse; hi/lo hold the new result in this cycle
div_by_zero  out  1  registered with done; high when the finished op was DIV/DIVU with b=0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0; done=0; div_by_zero=0; hi=0; lo=0; counter=0.
- Reset mid-operation has the same effect. The in-flight op is discarded and no done pulse is issued.
- States:
  - IDLE -> ITER when start=1.
  - ITER -> ITER while counter != 0; counter decrements each cycle.
  - ITER -> FIX when counter == 0.
  - FIX -> IDLE unconditionally.
- Start accept (IDLE with start=1):
  - latch op, a and b;
  - take the absolute values of a and b for signed ops and record the result and remainder signs;
  - record the divide-by-zero condition;
  - load counter = WIDTH-1.
- ITER, multiply: radix-2 shift-add on a 2*WIDTH accumulator, one bit per cycle.
- ITER, divide: restoring shift-subtract, one quotient bit per cycle.
- ITER length: exactly WIDTH cycles.
- FIX: apply sign correction and register the result into hi/lo. The next cycle shows busy=0, done=1 and the new hi/lo.
- busy is 1 for exactly WIDTH+1 cycles: all ITER cycles plus FIX.
- done is visible WIDTH+1 cycles after the accepting edge.
- Multiply results: {hi,lo} = full 2*WIDTH product. MULT is signed x signed; MULTU is unsigned x unsigned.
- DIV: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
- DIVU: unsigned quotient in lo, remainder in hi.
- DIV overflow (a = most negative value, b = all ones): lo = most negative value, hi = 0. No flag is raised.
- Divide by zero (DIV or DIVU): lo = all ones, hi = a as latched at start, div_by_zero=1 with done. The full WIDTH+1 latency is still taken.
- start while busy: ignored, with no effect on the in-flight op.
- mthi/mtlo while busy: ignored.
- mthi/mtlo in IDLE: the target register is updated on the next edge. Both may be asserted together and both are written.
- start together with mthi/mtlo in IDLE: start wins and the writes are dropped.
- done and div_by_zero are single-cycle pulses. done never coincides with busy=1.
- A new start may be issued in the same cycle as done (busy=0). That result is held in hi/lo until the next completion or write.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3;
  - the state enum {IDLE, ITER, FIX}.
- The decoder imports the op constants from mdu_pkg.
- One natural sub-module: mdu_step. It is the combinational single-iteration datapath: conditional add-and-shift for multiply, trial-subtract-and-shift for divide. It is parametrised by WIDTH, instantiated once, and driven by the FSM.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles; done pulses exactly once, 33 cycles after the accepting edge.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3, hi=1.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0. DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 with done.
- During a busy MULTU, pulse start with new operands and pulse mthi with wdata=0xAAAA -> both ignored and the original result is delivered. Then in IDLE, mtlo with wdata=0x1234 -> lo=0x1234 next cycle, hi unchanged.
- Assert reset at ITER cycle 10 -> next cycle busy=0, hi=lo=0, and no done ever follows. With a WIDTH=8 instance, DIVU a=200 b=7 -> lo=28, hi=4, done 9 cycles after the accepting edge.
